// File: rtl/mux_rr.sv
// Registered N-channel multiplexer with valid/ready handshake, fixed-select or round-robin grant.
// Build option: define MUX_RR_EN to build the round-robin pointer and search; otherwise mode is ignored.
module mux_rr #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset_a,
    input  logic [CHANNELS*WIDTH-1:0] mux_in,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          mux_sel,
    output logic [WIDTH-1:0]          mux_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_ch
);

    typedef enum logic {StEmpty, StFull} state_t;

    state_t           state, state_next;
    logic             load_ok;
    logic             xfer;
    logic             fix_vld;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;

    assign out_valid = (state == StFull);
    assign load_ok   = !out_valid || out_ready;

    // Out-of-range selects are short-circuited before in_valid is indexed.
    assign fix_vld = (int'(mux_sel) < CHANNELS) && in_valid[mux_sel];

`ifdef MUX_RR_EN
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] rr_idx;
    logic [SEL_W-1:0] cand;
    logic             rr_vld;

    always_comb begin
        rr_vld = 1'b0;
        rr_idx = '0;
        cand   = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            cand = SEL_W'((int'(ptr) + k) % CHANNELS);
            if (!rr_vld && in_valid[cand]) begin
                rr_vld = 1'b1;
                rr_idx = cand;
            end
        end
    end

    // ptr starts at the last channel so channel 0 wins first after reset.
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            ptr <= SEL_W'(CHANNELS - 1);
        end else if (xfer && mode) begin
            ptr <= grant_idx;
        end
    end

    always_comb begin
        grant_vld = fix_vld;
        grant_idx = mux_sel;
        if (mode) begin
            grant_vld = rr_vld;
            grant_idx = rr_idx;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    always_comb begin
        grant_vld = fix_vld;
        grant_idx = mux_sel;
    end
`endif

    assign xfer = grant_vld && load_ok;

    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(grant_idx) == i) begin
                in_ready[i] = xfer;
                grant_data  = mux_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            StEmpty: if (xfer) state_next = StFull;
            StFull:  if (!xfer && out_ready) state_next = StEmpty;
            default: state_next = StEmpty;
        endcase
    end

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state <= StEmpty;
        end else begin
            state <= state_next;
        end
    end

    // Data and channel index hold their last values after a drain.
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            mux_out <= '0;
            out_ch  <= '0;
        end else if (xfer) begin
            mux_out <= grant_data;
            out_ch  <= grant_idx;
        end
    end

endmodule

// File: tb/tb_mux_rr.sv
// Self-checking bench for mux_rr: directed scenarios plus randomized traffic against a
// transfer-level reference model.
module tb_mux_rr;

    localparam int W = 4;
    localparam int C = 4;
`ifdef MUX_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_a;
    logic [C*W-1:0] mux_in;
    logic [C-1:0]  in_valid;
    logic [C-1:0]  in_ready;
    logic          mode;
    logic [1:0]    mux_sel;
    logic [W-1:0]  mux_out;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_ch;

    logic [11:0]   mux_in3;
    logic [2:0]    in_valid3;
    logic [2:0]    in_ready3;
    logic [1:0]    mux_sel3;
    logic [W-1:0]  mux_out3;
    logic          out_valid3;
    logic [1:0]    out_ch3;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit         m_valid;
    logic [3:0] m_data;
    logic [1:0] m_ch;
    int         m_ptr;

    always #5 clk = ~clk;

    mux_rr #(.WIDTH(W), .CHANNELS(C), .SEL_W(2)) dut (
        .clk       (clk),
        .reset_a   (reset_a),
        .mux_in    (mux_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .mux_sel   (mux_sel),
        .mux_out   (mux_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
    );

    mux_rr #(.WIDTH(W), .CHANNELS(3), .SEL_W(2)) dut3 (
        .clk       (clk),
        .reset_a   (reset_a),
        .mux_in    (mux_in3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (mode),
        .mux_sel   (mux_sel3),
        .mux_out   (mux_out3),
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .out_ch    (out_ch3)
    );

    // Granted channel under the spec rules, or -1 for none.
    function automatic int exp_grant();
        if (mode && RR) begin
            for (int k = 1; k <= C; k++) begin
                int c;
                c = (m_ptr + k) % C;
                if (in_valid[c]) return c;
            end
            return -1;
        end
        return in_valid[mux_sel] ? int'(mux_sel) : -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        logic [3:0] r;
        int g;
        r = '0;
        g = exp_grant();
        if (g >= 0 && (!m_valid || out_ready)) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = '0;
        m_ptr   = C - 1;
    endtask

    // Advance one clock edge and update the model with the inputs seen at that edge.
    task automatic cycle();
        int g;
        bit x;
        logic [C*W-1:0] d;
        g = exp_grant();
        x = (g >= 0) && (!m_valid || out_ready);
        d = mux_in >> (g * W);
        @(posedge clk);
        if (x) begin
            m_data  = d[3:0];
            m_ch    = 2'(g);
            m_valid = 1'b1;
            if (mode && RR) m_ptr = g;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_a = 1'b1;
        model_reset();
        @(negedge clk);
        reset_a = 1'b0;
    endtask

    task automatic test_reset();
        reset_a = 1'b1; mux_in = '0; in_valid = '0; mode = 1'b0; mux_sel = '0; out_ready = 1'b0;
        mux_in3 = '0; in_valid3 = '0; mux_sel3 = '0;
        model_reset();
        #1;
        total++; if (mux_out !== 4'h0) begin bad++; $display("FAIL reset_mux_out: got %h want 0", mux_out); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_ch !== 2'd0) begin bad++; $display("FAIL reset_out_ch: got %0d want 0", out_ch); end
        @(negedge clk);
        reset_a = 1'b0;
        @(negedge clk);
        mode = 1'b0; mux_sel = 2'd3; in_valid = 4'b1000; mux_in = 16'h9000; out_ready = 1'b0;
        cycle();
        total++; if (out_valid !== 1'b1 || mux_out !== 4'h9) begin
            bad++; $display("FAIL reset_preload: got v=%b d=%h want v=1 d=9", out_valid, mux_out);
        end
        #2;
        reset_a = 1'b1;
        model_reset();
        #1;
        total++; if (mux_out !== 4'h0) begin bad++; $display("FAIL midreset_mux_out: got %h want 0", mux_out); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
        total++; if (out_ch !== 2'd0) begin bad++; $display("FAIL midreset_out_ch: got %0d want 0", out_ch); end
        @(negedge clk);
        reset_a = 1'b0;
        in_valid = '0;
    endtask

    task automatic test_fixed();
        @(negedge clk);
        mode = 1'b0; mux_sel = 2'd2; in_valid = 4'hF; mux_in = 16'h3A21; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL fixed_in_ready: got %b want 0100", in_ready); end
        cycle();
        total++; if (mux_out !== 4'hA) begin bad++; $display("FAIL fixed_mux_out: got %h want a", mux_out); end
        total++; if (out_ch !== 2'd2) begin bad++; $display("FAIL fixed_out_ch: got %0d want 2", out_ch); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fixed_out_valid: got %b want 1", out_valid); end
    endtask

    task automatic test_rr_fair();
        logic [3:0] er;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1; mux_sel = 2'(i); mux_in = 16'($urandom);
            #1;
            er = exp_ready();
            total++; if (in_ready !== er) begin bad++; $display("FAIL rr_fair_in_ready[%0d]: got %b want %b", i, in_ready, er); end
            cycle();
            total++; if (out_ch !== m_ch || mux_out !== m_data) begin
                bad++; $display("FAIL rr_fair_out[%0d]: got ch=%0d d=%h want ch=%0d d=%h", i, out_ch, mux_out, m_ch, m_data);
            end
        end
    endtask

    task automatic test_rr_skip();
        logic [3:0] vals [2];
        logic [3:0] er;
        vals[0] = 4'b0100;
        vals[1] = 4'b0011;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mode = 1'b1; mux_sel = 2'd2; out_ready = 1'b1; in_valid = vals[i]; mux_in = 16'($urandom);
            #1;
            er = exp_ready();
            total++; if (in_ready !== er) begin bad++; $display("FAIL rr_skip_in_ready[%0d]: got %b want %b", i, in_ready, er); end
            cycle();
            total++; if (out_ch !== m_ch || out_valid !== m_valid || mux_out !== m_data) begin
                bad++; $display("FAIL rr_skip_out[%0d]: got ch=%0d v=%b d=%h want ch=%0d v=%b d=%h",
                                i, out_ch, out_valid, mux_out, m_ch, m_valid, m_data);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] held_d;
        logic [1:0] held_ch;
        @(negedge clk);
        mode = 1'b0; mux_sel = 2'd1; in_valid = 4'hF; out_ready = 1'b1; mux_in = 16'($urandom);
        cycle();
        held_d  = m_data;
        held_ch = m_ch;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 4'($urandom); mux_sel = 2'($urandom); mux_in = 16'($urandom);
            mode = 1'($urandom);
            #1;
            total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", i, in_ready); end
            cycle();
            total++; if (mux_out !== held_d || out_ch !== held_ch || out_valid !== 1'b1) begin
                bad++; $display("FAIL bp_hold[%0d]: got d=%h ch=%0d v=%b want d=%h ch=%0d v=1",
                                i, mux_out, out_ch, out_valid, held_d, held_ch);
            end
        end
        @(negedge clk);
        mode = 1'b0; mux_sel = 2'd1; in_valid = 4'hF; out_ready = 1'b1; mux_in = 16'($urandom);
        #1;
        total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL bp_release_in_ready: got %b want 0010", in_ready); end
        cycle();
        total++; if (out_valid !== 1'b1 || mux_out !== m_data || out_ch !== 2'd1) begin
            bad++; $display("FAIL bp_release_out: got v=%b d=%h ch=%0d want v=1 d=%h ch=1",
                            out_valid, mux_out, out_ch, m_data);
        end
    endtask

    task automatic test_random();
        logic [3:0] er;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            mux_in    = 16'($urandom);
            in_valid  = 4'($urandom) & 4'($urandom);
            mux_sel   = 2'($urandom);
            mode      = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            er = exp_ready();
            total++; if (in_ready !== er) begin bad++; $display("FAIL rand_in_ready[%0d]: got %b want %b", i, in_ready, er); end
            cycle();
            total++; if (out_valid !== m_valid || mux_out !== m_data || out_ch !== m_ch) begin
                bad++; $display("FAIL rand_out[%0d]: got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d",
                                i, out_valid, mux_out, out_ch, m_valid, m_data, m_ch);
            end
        end
    endtask

    task automatic test_oor();
        do_reset();
        @(negedge clk);
        mode = 1'b0; in_valid = '0; out_ready = 1'b0;
        mux_sel3 = 2'd3; in_valid3 = 3'b111; mux_in3 = 12'h5B7;
        #1;
        total++; if (in_ready3 !== 3'b000) begin bad++; $display("FAIL oor_in_ready: got %b want 000", in_ready3); end
        @(posedge clk); #1;
        total++; if (out_valid3 !== 1'b0) begin bad++; $display("FAIL oor_out_valid: got %b want 0", out_valid3); end
        @(negedge clk);
        mux_sel3 = 2'd2;
        #1;
        total++; if (in_ready3 !== 3'b100) begin bad++; $display("FAIL oor_sel2_in_ready: got %b want 100", in_ready3); end
        @(posedge clk); #1;
        total++; if (out_valid3 !== 1'b1 || mux_out3 !== 4'h5 || out_ch3 !== 2'd2) begin
            bad++; $display("FAIL oor_sel2_out: got v=%b d=%h ch=%0d want v=1 d=5 ch=2", out_valid3, mux_out3, out_ch3);
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr_fair();
        test_rr_skip();
        test_backpressure();
        test_random();
        test_oor();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
